// File: rtl/eth_cmd_pkg.sv
// Shared definitions for the Ethernet command parser: FSM state encoding,
// frame field offsets, op codes, broadcast MAC and the byte-counter helper.
// No ports (package).
package eth_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdr   = 3'd1,
    StBody  = 3'd2,
    StDrain = 3'd3,
    StEmit  = 3'd4,
    StDrop  = 3'd5
  } state_e;

  // Byte offsets within a frame, counted from the first beat after IDLE.
  localparam logic [10:0] OFF_TAG  = 11'd16;
  localparam logic [10:0] OFF_OP   = 11'd18;
  localparam logic [10:0] OFF_ID   = 11'd20;
  localparam logic [10:0] OFF_ADDR = 11'd24;
  localparam logic [10:0] OFF_DATA = 11'd28;

  localparam logic [7:0] OP_WR = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD = 8'h52;  // 'R'

  localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

  localparam logic [10:0] CNT_MAX = 11'h7ff;

  // Saturating increment of the 11-bit byte counter.
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/eth_cmd_sat_cnt.sv
// 16-bit saturating event counter.
// Ports: clk_i (clock), rst_ni (async active-low reset), inc_i (count enable),
//        cnt_o (current count, sticks at 0xFFFF).
module eth_cmd_sat_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 16'hffff)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_cmd_parser.sv
// Ethernet command parser: consumes an AXI-Stream byte stream of raw frames,
// validates dst MAC / tag / op, captures cmd_id, address and data
// (little-endian) and presents one command on a per-channel valid/ready port.
// Ports:
//   gtx_clk_bufg, gtx_resetn            clock, async active-low reset
//   rx_axis_t{data,valid,last,user}     frame byte stream in
//   rx_axis_tready                      byte accept (low while a command waits)
//   cmd_valid[NUM_CH] / cmd_ready       one-hot command handshake
//   cmd_write, cmd_id, cmd_addr, cmd_data  command fields
//   frame_ok_cnt, frame_err_cnt         saturating accepted/dropped counters
// Build option: define ETH_CMD_PARSER_BCAST_EN to also accept the broadcast
// destination MAC.
module eth_cmd_parser
  import eth_cmd_pkg::*;
#(
  parameter int unsigned          NUM_CH   = 2,
  parameter logic [NUM_CH*8-1:0]  CH_TAGS  = {8'h43, 8'h46},
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [47:0]          FPGA_MAC = 48'h5a0102030405
) (
  input  logic              gtx_clk_bufg,
  input  logic              gtx_resetn,
  input  logic [7:0]        rx_axis_tdata,
  input  logic              rx_axis_tvalid,
  input  logic              rx_axis_tlast,
  input  logic              rx_axis_tuser,
  output logic              rx_axis_tready,
  output logic [NUM_CH-1:0] cmd_valid,
  input  logic [NUM_CH-1:0] cmd_ready,
  output logic              cmd_write,
  output logic [31:0]       cmd_id,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic [15:0]       frame_ok_cnt,
  output logic [15:0]       frame_err_cnt
);

  // Offset of the last byte a frame must carry to be complete.
  localparam logic [10:0] LAST_OFF = 11'(27 + DATA_W / 8);

  state_e              state_q, state_d;
  logic [10:0]         cnt_q, cnt_d;
  logic                mac_q, mac_d;    // dst matches FPGA_MAC so far
  logic                bc_q, bc_d;      // dst matches broadcast so far
  logic [7:0]          tag_q, tag_d;
  logic [7:0]          op_q, op_d;
  logic [1:0]          ch_q, ch_d;
  logic                write_q, write_d;
  logic [31:0]         id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tready_q, tready_d;

  logic        beat;
  logic        bad;
  logic        ok_inc, err_inc;
  logic [7:0]  mac_byte;
  logic        mac_hit, bc_hit;
  logic        tag_hit;
  logic [1:0]  tag_ch;
  logic        rdy_sel;
  logic [31:0] addr_w;

  assign beat = rx_axis_tvalid && tready_q;

  // Per-byte lookups: expected MAC byte, tag-to-channel map, selected ready.
  always_comb begin
    mac_byte = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (cnt_q == 11'(k)) mac_byte = FPGA_MAC[8*(5-k) +: 8];
    end
    tag_hit = 1'b0;
    tag_ch  = 2'd0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (CH_TAGS[8*i +: 8] == rx_axis_tdata) begin
        tag_hit = 1'b1;
        tag_ch  = 2'(i);
      end
    end
    rdy_sel = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch_q == 2'(i)) rdy_sel = cmd_ready[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mac_d   = mac_q;
    bc_d    = bc_q;
    tag_d   = tag_q;
    op_d    = op_q;
    ch_d    = ch_q;
    write_d = write_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = data_q;
    addr_w  = 32'(addr_q);
    ok_inc  = 1'b0;
    err_inc = 1'b0;
    bad     = 1'b0;
    mac_hit = 1'b0;
    bc_hit  = 1'b0;

    unique case (state_q)
      StIdle, StHdr, StBody, StDrain: begin
        if (beat) begin
          cnt_d = sat_inc11(cnt_q);

          // The dst MAC is matched byte by byte so a mismatch drops the
          // frame right after the offending byte.
          if (cnt_q < 11'd6) begin
            mac_hit = ((cnt_q == 11'd0) || mac_q) && (rx_axis_tdata == mac_byte);
`ifdef ETH_CMD_PARSER_BCAST_EN
            bc_hit  = ((cnt_q == 11'd0) || bc_q) && (rx_axis_tdata == BCAST_MAC[7:0]);
`else
            bc_hit  = 1'b0;
`endif
            mac_d = mac_hit;
            bc_d  = bc_hit;
            bad   = !(mac_hit || bc_hit);
          end

          if (cnt_q == OFF_TAG) tag_d = rx_axis_tdata;
          if (cnt_q == OFF_TAG + 11'd1) begin
            bad  = (rx_axis_tdata != tag_q) || !tag_hit;
            ch_d = tag_ch;
          end
          if (cnt_q == OFF_OP) op_d = rx_axis_tdata;
          if (cnt_q == OFF_OP + 11'd1) begin
            bad     = (rx_axis_tdata != op_q) ||
                      !((rx_axis_tdata == OP_WR) || (rx_axis_tdata == OP_RD));
            write_d = (rx_axis_tdata == OP_WR);
          end

          for (int k = 0; k < 4; k++) begin
            if (cnt_q == OFF_ID + 11'(k)) id_d[8*k +: 8] = rx_axis_tdata;
            if (cnt_q == OFF_ADDR + 11'(k)) addr_w[8*k +: 8] = rx_axis_tdata;
          end
          addr_d = addr_w[ADDR_W-1:0];
          for (int k = 0; k < int'(DATA_W / 8); k++) begin
            if (cnt_q == OFF_DATA + 11'(k)) data_d[8*k +: 8] = rx_axis_tdata;
          end

          if (rx_axis_tlast) begin
            state_d = StIdle;
            cnt_d   = 11'd0;
            // Bad check byte, runt, or errored frame: count it and discard.
            if (bad || (cnt_q < LAST_OFF) || rx_axis_tuser) begin
              err_inc = 1'b1;
            end else begin
              state_d = StEmit;
            end
          end else if (bad) begin
            state_d = StDrop;
          end else if (cnt_q < OFF_ID - 11'd1) begin
            state_d = StHdr;
          end else if (cnt_q < LAST_OFF) begin
            state_d = StBody;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StEmit: begin
        if (rdy_sel) begin
          state_d = StIdle;
          ok_inc  = 1'b1;
        end
      end
      StDrop: begin
        if (beat && rx_axis_tlast) begin
          state_d = StIdle;
          cnt_d   = 11'd0;
          err_inc = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 11'd0;
      end
    endcase

    tready_d = (state_d != StEmit);
  end

  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 11'd0;
      mac_q    <= 1'b0;
      bc_q     <= 1'b0;
      tag_q    <= 8'd0;
      op_q     <= 8'd0;
      ch_q     <= 2'd0;
      write_q  <= 1'b0;
      id_q     <= 32'd0;
      addr_q   <= '0;
      data_q   <= '0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mac_q    <= mac_d;
      bc_q     <= bc_d;
      tag_q    <= tag_d;
      op_q     <= op_d;
      ch_q     <= ch_d;
      write_q  <= write_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tready_q <= tready_d;
    end
  end

  always_comb begin
    cmd_valid = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cmd_valid[i] = (state_q == StEmit) && (ch_q == 2'(i));
    end
  end

  assign rx_axis_tready = tready_q;
  assign cmd_write      = write_q;
  assign cmd_id         = id_q;
  assign cmd_addr       = addr_q;
  assign cmd_data       = data_q;

  eth_cmd_sat_cnt u_ok_cnt (
    .clk_i  (gtx_clk_bufg),
    .rst_ni (gtx_resetn),
    .inc_i  (ok_inc),
    .cnt_o  (frame_ok_cnt)
  );

  eth_cmd_sat_cnt u_err_cnt (
    .clk_i  (gtx_clk_bufg),
    .rst_ni (gtx_resetn),
    .inc_i  (err_inc),
    .cnt_o  (frame_err_cnt)
  );

endmodule

// File: tb/tb_eth_cmd_parser.sv
// Bench for eth_cmd_parser: a default instance checked through a command
// scoreboard, plus a 4-channel / 64-bit instance fed the same byte stream.
module tb_eth_cmd_parser;

  localparam logic [47:0] MAC = 48'h5a0102030405;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [1:0]  vld;
    logic        wr;
    logic [31:0] id;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser;
  logic        tready;
  logic [1:0]  cmd_valid, cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_id, cmd_addr, cmd_data;
  logic [15:0] ok_cnt, err_cnt;

  logic        tready64;
  logic [3:0]  valid64;
  logic        write64;
  logic [31:0] id64, addr64;
  logic [63:0] data64;
  logic [15:0] ok64, err64;

  int   errors = 0;
  int   checks = 0;
  int   exp_ok = 0;
  int   exp_err = 0;
  exp_t exp_q[$];

  eth_cmd_parser dut (
    .gtx_clk_bufg   (clk),
    .gtx_resetn     (rst_n),
    .rx_axis_tdata  (tdata),
    .rx_axis_tvalid (tvalid),
    .rx_axis_tlast  (tlast),
    .rx_axis_tuser  (tuser),
    .rx_axis_tready (tready),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_id         (cmd_id),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .frame_ok_cnt   (ok_cnt),
    .frame_err_cnt  (err_cnt)
  );

  eth_cmd_parser #(
    .NUM_CH  (4),
    .CH_TAGS ({8'h41, 8'h42, 8'h43, 8'h46}),
    .DATA_W  (64)
  ) dut64 (
    .gtx_clk_bufg   (clk),
    .gtx_resetn     (rst_n),
    .rx_axis_tdata  (tdata),
    .rx_axis_tvalid (tvalid),
    .rx_axis_tlast  (tlast),
    .rx_axis_tuser  (tuser),
    .rx_axis_tready (tready64),
    .cmd_valid      (valid64),
    .cmd_ready      (4'hf),
    .cmd_write      (write64),
    .cmd_id         (id64),
    .cmd_addr       (addr64),
    .cmd_data       (data64),
    .frame_ok_cnt   (ok64),
    .frame_err_cnt  (err64)
  );

  // Scoreboard: every accepted command must match the oldest expectation.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && ((cmd_valid & cmd_ready) != 2'b00)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got valid=%b id=%h, none expected", cmd_valid, cmd_id);
      end else begin
        e = exp_q.pop_front();
        if ({cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_data} !== e) begin
          errors++;
          $display("FAIL cmd_fields: got %b/%b/%h/%h/%h, need %b/%b/%h/%h/%h",
                   cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_data,
                   e.vld, e.wr, e.id, e.addr, e.data);
        end
      end
    end
  end

  function automatic bq_t mk(input logic [47:0] dst, input logic [7:0] t0, input logic [7:0] t1,
                             input logic [7:0] o0, input logic [7:0] o1, input logic [31:0] id,
                             input logic [31:0] addr, input logic [63:0] data, input int len);
    bq_t f;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'(i);
      if (i < 6) b = dst[8*(5-i) +: 8];
      else if (i == 16) b = t0;
      else if (i == 17) b = t1;
      else if (i == 18) b = o0;
      else if (i == 19) b = o1;
      else if (i >= 20 && i < 24) b = id[8*(i-20) +: 8];
      else if (i >= 24 && i < 28) b = addr[8*(i-24) +: 8];
      else if (i >= 28 && i < 36) b = data[8*(i-28) +: 8];
      f.push_back(b);
    end
    return f;
  endfunction

  task automatic push_exp(input logic [1:0] v, input logic w, input logic [31:0] id,
                          input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e = '{vld: v, wr: w, id: id, addr: a, data: d};
    exp_q.push_back(e);
  endtask

  // Drives one frame; tuser is random on non-last beats and bad_user on tlast.
  task automatic send(input bq_t f, input logic bad_user);
    int g;
    repeat (2) @(negedge clk);
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      tdata  = f[i];
      tvalid = 1'b1;
      tlast  = (i == f.size() - 1);
      tuser  = tlast ? bad_user : 1'($urandom_range(0, 1));
      g = 0;
      while (!tready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_stall: tready=%b at byte %0d, need 1", tready, i);
      end
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic wait_sb();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00; cmd_ready = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tready !== 1'b0 || tready64 !== 1'b0) begin
      errors++; $display("FAIL reset_tready: got %b/%b, need 0/0", tready, tready64);
    end
    checks++;
    if (cmd_valid !== 2'b00 || valid64 !== 4'h0) begin
      errors++; $display("FAIL reset_valid: got %b/%b, need 0/0", cmd_valid, valid64);
    end
    checks++;
    if ({cmd_write, cmd_id, cmd_addr, cmd_data} !== 97'd0) begin
      errors++; $display("FAIL reset_fields: got %b/%h/%h/%h, need 0", cmd_write, cmd_id, cmd_addr, cmd_data);
    end
    checks++;
    if (ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d, need 0/0", ok_cnt, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++;
    if (tready !== 1'b0) begin
      errors++; $display("FAIL tready_before_clock: got %b, need 0", tready);
    end
    @(negedge clk);
    checks++;
    if (tready !== 1'b1) begin
      errors++; $display("FAIL tready_after_release: got %b, need 1", tready);
    end
  endtask

  task automatic test_write();
    cmd_ready = 2'b11;
    push_exp(2'b01, 1'b1, 32'h17fc, 32'h1e, 32'h4);
    send(mk(MAC, 8'h46, 8'h46, 8'h57, 8'h57, 32'h17fc, 32'h1e, 64'h4, 32), 1'b0);
    checks++;
    if (cmd_valid !== 2'b01 || tready !== 1'b0) begin
      errors++; $display("FAIL write_emit: got valid=%b tready=%b, need 01/0", cmd_valid, tready);
    end
    wait_sb();
    exp_ok++;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL write_timeout: %0d commands outstanding, need 0", exp_q.size());
    end
    checks++;
    if (ok_cnt !== 16'(exp_ok)) begin
      errors++; $display("FAIL write_ok_cnt: got %0d, need %0d", ok_cnt, exp_ok);
    end
  endtask

  task automatic test_hold();
    int bad_cycles = 0;
    cmd_ready = 2'b00;
    push_exp(2'b10, 1'b0, 32'ha5a50001, 32'h100, 32'hdeadbeef);
    send(mk(MAC, 8'h43, 8'h43, 8'h52, 8'h52, 32'ha5a50001, 32'h100, 64'hdeadbeef, 32), 1'b0);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (cmd_valid !== 2'b10 || tready !== 1'b0 || cmd_write !== 1'b0 ||
          cmd_id !== 32'ha5a50001 || cmd_addr !== 32'h100 || cmd_data !== 32'hdeadbeef) begin
        errors++; bad_cycles++;
        $display("FAIL hold_cycle%0d: got %b/%b/%b/%h/%h/%h, need 10/0/0/a5a50001/100/deadbeef",
                 c, cmd_valid, tready, cmd_write, cmd_id, cmd_addr, cmd_data);
      end
      @(negedge clk);
    end
    cmd_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (tready !== 1'b1 || cmd_valid !== 2'b00) begin
      errors++; $display("FAIL hold_release: got tready=%b valid=%b, need 1/00", tready, cmd_valid);
    end
    wait_sb();
    exp_ok++;
    checks++;
    if (ok_cnt !== 16'(exp_ok) || exp_q.size() != 0) begin
      errors++; $display("FAIL hold_ok_cnt: got %0d (q=%0d), need %0d", ok_cnt, exp_q.size(), exp_ok);
    end
  endtask

  task automatic test_errors();
    bq_t f;
    cmd_ready = 2'b11;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: f = mk(48'h5a0102030406, 8'h46, 8'h46, 8'h57, 8'h57, 32'h1, 32'h2, 64'h3, 32);
        1: f = mk(MAC, 8'h46, 8'h43, 8'h57, 8'h57, 32'h1, 32'h2, 64'h3, 32);
        2: f = mk(MAC, 8'h46, 8'h46, 8'h57, 8'h52, 32'h1, 32'h2, 64'h3, 32);
        3: f = mk(MAC, 8'h46, 8'h46, 8'h57, 8'h57, 32'h1, 32'h2, 64'h3, 20);
        4: f = mk(MAC, 8'h46, 8'h46, 8'h57, 8'h57, 32'h1, 32'h2, 64'h3, 32);
        5: f = mk(MAC, 8'h46, 8'h46, 8'h57, 8'h57, 32'h1, 32'h2, 64'h3, 31);
        default: f = mk(MAC, 8'h44, 8'h44, 8'h57, 8'h57, 32'h1, 32'h2, 64'h3, 40);
      endcase
      send(f, (i == 4));
      exp_err++;
      repeat (2) @(negedge clk);
      checks++;
      if (err_cnt !== 16'(exp_err) || ok_cnt !== 16'(exp_ok)) begin
        errors++; $display("FAIL bad_frame%0d: got err=%0d ok=%0d, need err=%0d ok=%0d",
                           i, err_cnt, ok_cnt, exp_err, exp_ok);
      end
    end
  endtask

  task automatic test_bcast();
    cmd_ready = 2'b11;
`ifdef ETH_CMD_PARSER_BCAST_EN
    push_exp(2'b01, 1'b1, 32'hb0, 32'hb1, 32'hb2);
    exp_ok++;
`else
    exp_err++;
`endif
    send(mk(48'hffffffffffff, 8'h46, 8'h46, 8'h57, 8'h57, 32'hb0, 32'hb1, 64'hb2, 32), 1'b0);
    wait_sb();
    checks++;
    if (err_cnt !== 16'(exp_err) || ok_cnt !== 16'(exp_ok) || exp_q.size() != 0) begin
      errors++; $display("FAIL bcast: got err=%0d ok=%0d q=%0d, need err=%0d ok=%0d q=0",
                         err_cnt, ok_cnt, exp_q.size(), exp_err, exp_ok);
    end
  endtask

  task automatic test_wide();
    int exp_err64;
    cmd_ready = 2'b11;
    // The wide instance has seen only runts or bad frames so far.
`ifdef ETH_CMD_PARSER_BCAST_EN
    exp_err64 = 10;
`else
    exp_err64 = 10;
`endif
    send(mk(MAC, 8'h41, 8'h41, 8'h57, 8'h57, 32'h11223344, 32'h80,
            64'h0807060504030201, 36), 1'b0);
    checks++;
    if (valid64 !== 4'b1000 || write64 !== 1'b1) begin
      errors++; $display("FAIL wide_valid: got %b/%b, need 1000/1", valid64, write64);
    end
    checks++;
    if (data64 !== 64'h0807060504030201 || id64 !== 32'h11223344 || addr64 !== 32'h80) begin
      errors++; $display("FAIL wide_fields: got %h/%h/%h, need 0807060504030201/11223344/80",
                         data64, id64, addr64);
    end
    checks++;
    if (cmd_valid !== 2'b00) begin
      errors++; $display("FAIL wide_narrow_valid: got %b, need 00", cmd_valid);
    end
    repeat (2) @(negedge clk);
    exp_err++;
    checks++;
    if (err_cnt !== 16'(exp_err) || ok64 !== 16'd1 || err64 !== 16'(exp_err64)) begin
      errors++; $display("FAIL wide_counts: got err=%0d ok64=%0d err64=%0d, need %0d/1/%0d",
                         err_cnt, ok64, err64, exp_err, exp_err64);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  tg, op;
    logic [31:0] id, ad, dt;
    int          len;
    cmd_ready = 2'b11;
    for (int n = 0; n < 6; n++) begin
      tg  = ($urandom_range(0, 1) == 0) ? 8'h46 : 8'h43;
      op  = ($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52;
      id  = $urandom;
      ad  = $urandom;
      dt  = $urandom;
      len = (n == 3) ? 2100 : 32 + int'($urandom_range(0, 20));
      push_exp((tg == 8'h46) ? 2'b01 : 2'b10, (op == 8'h57), id, ad, dt);
      send(mk(MAC, tg, tg, op, op, id, ad, {32'h0, dt}, len), 1'b0);
      exp_ok++;
    end
    wait_sb();
    checks++;
    if (exp_q.size() != 0 || ok_cnt !== 16'(exp_ok)) begin
      errors++; $display("FAIL back_to_back: got ok=%0d q=%0d, need ok=%0d q=0",
                         ok_cnt, exp_q.size(), exp_ok);
    end
  endtask

  task automatic test_reset_emit();
    cmd_ready = 2'b00;
    send(mk(MAC, 8'h46, 8'h46, 8'h57, 8'h57, 32'h77, 32'h88, 64'h99, 32), 1'b0);
    checks++;
    if (cmd_valid !== 2'b01) begin
      errors++; $display("FAIL pre_reset_emit: got %b, need 01", cmd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_data, ok_cnt, err_cnt, tready} !== 132'd0) begin
      errors++; $display("FAIL reset_in_emit: got %b/%b/%h/%h/%h/%0d/%0d/%b, need all 0",
                         cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_data, ok_cnt, err_cnt, tready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    exp_ok    = 0;
    exp_err   = 0;
    cmd_ready = 2'b11;
    push_exp(2'b10, 1'b1, 32'h12345678, 32'hcafe, 32'h0badf00d);
    send(mk(MAC, 8'h43, 8'h43, 8'h57, 8'h57, 32'h12345678, 32'hcafe, 64'h0badf00d, 32), 1'b0);
    wait_sb();
    exp_ok++;
    checks++;
    if (exp_q.size() != 0 || ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
      errors++; $display("FAIL after_reset_frame: got ok=%0d err=%0d q=%0d, need %0d/%0d/0",
                         ok_cnt, err_cnt, exp_q.size(), exp_ok, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_hold();
    test_errors();
    test_bcast();
    test_wide();
    test_back_to_back();
    test_reset_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_cmd_parser.md
ETH_CMD_PARSER -- requirements
Module: eth_cmd_parser

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_CH, 2, command channels, legal 1..4
- CH_TAGS, {8'h43,8'h46}, NUM_CH*8 bits; byte i is the tag of channel i (ch0 0x46 'F', ch1 0x43 'C')
- ADDR_W, 32, command address width, legal 1..32
- DATA_W, 32, command data width, legal 32 or 64
- FPGA_MAC, 48'h5a0102030405, accepted destination MAC
REQ-002 Ports (name, direction, width, meaning):
- gtx_clk_bufg, in, 1, sole clock
- gtx_resetn, in, 1, asynchronous active-low reset
- rx_axis_tdata/tvalid/tlast/tuser, in, 8/1/1/1, frame byte stream; tuser on the tlast beat marks a bad frame
- rx_axis_tready, out, 1, byte accept
- cmd_valid, out, NUM_CH, one-hot command strobe
- cmd_ready, in, NUM_CH, per-channel accept
- cmd_write, out, 1, 1 = write ('W'), 0 = read ('R')
- cmd_id, out, 32, command ID
- cmd_addr, out, ADDR_W, address
- cmd_data, out, DATA_W, write data
- frame_ok_cnt, out, 16, accepted-command count
- frame_err_cnt, out, 16, dropped-frame count

Function
REQ-003 Byte offsets are counted from the first beat after IDLE:
- 0-5 dst MAC; 6-11 src MAC; 12-13 length; 14-15 reserved (ignored)
- 16-17 tag; 18-19 op
- 20-23 cmd_id, little-endian; 24-27 addr, little-endian, truncated to ADDR_W
- 28..27+DATA_W/8 data, little-endian
- minimum frame length L = 28+DATA_W/8 bytes; bytes beyond L are ignored up to tlast.
REQ-004 States are IDLE, HDR, BODY, DRAIN, EMIT and DROP; a beat is consumed only when tvalid && tready.
REQ-005 IDLE goes to HDR on the first consumed beat; HDR captures bytes 0-19; BODY captures bytes 20..L-1; DRAIN consumes bytes until tlast.
REQ-006 DROP: a frame that fails any check enters DROP, which consumes bytes to tlast, then goes to IDLE and increments frame_err_cnt. Checks:
- dst MAC != FPGA_MAC
- tag bytes 16 and 17 unequal, or not present in CH_TAGS
- op bytes 18 and 19 unequal, or neither 0x57 nor 0x52
REQ-007 A frame failing a check goes to DROP in the cycle after the offending byte is consumed.
REQ-008 Runt frame: tlast before byte L-1 goes to IDLE and increments frame_err_cnt; no command is issued.
REQ-009 tlast with tuser=1 on an otherwise good frame goes to IDLE and increments frame_err_cnt; no command is issued.
REQ-010 Good frame: tlast with tuser=0 goes to EMIT; cmd_valid[ch] asserts in the cycle after the tlast beat; frame_ok_cnt increments on acceptance.
REQ-011 In EMIT, rx_axis_tready=0; cmd_* outputs are held stable until cmd_ready[ch]=1; tready returns to 1 in the cycle after acceptance.
REQ-012 tlast on byte L-1 is legal and goes directly to EMIT.
REQ-013 The byte counter is 11 bits and saturates at 2047; frames longer than 2047 bytes are still drained to tlast.
REQ-014 Both counters saturate at 0xFFFF.
REQ-015 Outside EMIT, rx_axis_tready=1.
REQ-016 tuser is ignored on beats without tlast.

Reset
REQ-017 gtx_resetn low asynchronously forces: state IDLE, cmd_valid=0, cmd_write=0, cmd_id/cmd_addr/cmd_data=0, both counters 0, rx_axis_tready=0.
REQ-018 rx_axis_tready rises in the first clock after reset release.
REQ-019 A command pending in EMIT when reset asserts is lost.
REQ-020 Upstream guarantees reset is released only at a frame boundary.

Configuration
REQ-021 Macro ETH_CMD_PARSER_BCAST_EN:
- defined: dst MAC 48'hffffffffffff is accepted as well as FPGA_MAC
- undefined: only FPGA_MAC is accepted, and broadcast frames go to DROP.

Structure
REQ-022 Package eth_cmd_pkg holds: the state enum, the field offset constants (16, 18, 20, 24, 28), the op codes OP_WR=8'h57 and OP_RD=8'h52, and the broadcast MAC constant.
REQ-023 One sub-module, eth_cmd_sat_cnt (a 16-bit saturating counter with increment enable), is instantiated twice; all other logic is in eth_cmd_parser.

Verification
REQ-024 Good write frame, defaults, bytes 16-31 = 46 46 57 57 fc 17 00 00 1e 00 00 00 04 00 00 00 -> cmd_valid=01, cmd_write=1, cmd_id=0x000017fc, cmd_addr=0x1e, cmd_data=4, frame_ok_cnt=1.
REQ-025 Read frame with tag 43 43 and op 52 52; cmd_ready held 0 for 10 cycles -> cmd_valid=10, cmd_write=0, rx_axis_tready=0 for those 10 cycles, outputs stable throughout.
REQ-026 Each of the following increments frame_err_cnt by 1 with no cmd_valid: dst MAC 5a0102030406; tag 46 43; op 57 52; a 20-byte runt; a good frame with tuser=1 on tlast.
REQ-027 Broadcast dst MAC -> a command is issued with the macro defined; frame_err_cnt increments without it.
REQ-028 DATA_W=64, NUM_CH=4, CH_TAGS={41,42,43,46}, tag 41, 36-byte frame with tlast on byte 35 -> cmd_valid=1000 with 64-bit LE data.
REQ-029 gtx_resetn pulsed low during EMIT -> all outputs zero immediately; the next good frame is parsed normally.
